monolith_job_sequencer: RTL
===========================

# monolith_job_sequencer

Upstream front end for the Monolith hash engine. Accepts one job per valid/ready transfer: a hash of one field element, or a compression of two. Canonicalises the operands modulo p = 2^31−1, drives the engine's operand/mode/go inputs with the required load-then-run sequencing, and returns the 31-bit digest on a valid/ready result port. Sits between the host-facing stream logic and the engine top; one job is in flight at a time.

## Interface
- TIMEOUT_CYCLES, 255: maximum number of RUN cycles before a job is aborted. Used only when MONOLITH_SEQ_WDT_EN is defined; legal range 1..65535.

- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- s_valid  in  1  job request valid
- s_ready  out  1  sequencer can accept a job
- s_in1  in  31  first operand
- s_in2  in  31  second operand, ignored in hash mode
- s_mode  in  1  0 = hash, 1 = compress
- m_valid  out  1  result valid
- m_ready  in  1  consumer accepts result
- m_data  out  31  digest
- m_err  out  1  job aborted by watchdog, qualified by m_valid
- eng_in1  out  31  engine operand 1
- eng_in2  out  31  engine operand 2
- eng_mode  out  1  engine hash_or_compress
- eng_go  out  1  engine go; low means the engine is held in reset
- eng_out  in  31  engine digest
- eng_valid  in  1  engine result valid

## Operation
- Registered FSM with states IDLE, LOAD, RUN, DONE.
- IDLE: s_ready=1. On s_valid&&s_ready:
  - register canonicalised operands: x==0x7FFF_FFFF → 0, otherwise x.
  - eng_in2 is forced to 0 when s_mode=0.
  - register eng_mode. Next state is LOAD.
- LOAD: exactly one cycle with eng_go=0. This lets the engine's input registers capture stable operands. Next state is RUN.
- RUN: eng_go=1. eng_valid is sampled only in RUN. When eng_valid=1:
  - m_data←eng_out, m_err←0
  - next state is DONE.
- DONE: eng_go=0, m_valid=1, m_data held stable. On m_ready=1, next state is IDLE.
- eng_in1, eng_in2 and eng_mode stay constant from LOAD through DONE. They change only on an accepted request.
- eng_go=1 only in RUN. DONE and IDLE always separate consecutive runs by at least 2 low cycles.
- s_ready=0 in LOAD, RUN and DONE. No request buffering.
- m_valid is never withdrawn before m_ready. m_data and m_err are stable while m_valid=1.
- Reset (async assert, any state):
  - state→IDLE
  - s_ready=1, m_valid=0, m_data=0, m_err=0
  - eng_in1=0, eng_in2=0, eng_mode=0, eng_go=0
  - Any in-flight job is discarded.
- Deassertion of reset_n is synchronised externally. The first active edge is in IDLE.

## Timing
- Accept at edge T0: LOAD during cycle T0..T1, eng_go high from T1.
- Let N be the number of RUN cycles up to and including the cycle in which eng_valid is sampled high. m_valid rises at edge T1+N, so accept-to-result latency is N+1 cycles.
- With m_ready held high, DONE lasts 1 cycle and s_ready returns 1 cycle later. Job period is N+3 cycles.
- s_valid may be asserted in any state; it is only accepted in IDLE.
- m_ready asserted before m_valid has no effect.

## Configuration
- MONOLITH_SEQ_WDT_EN defined: a 16-bit counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT_CYCLES without eng_valid: next state DONE with m_data=0, m_err=1.
  - eng_valid sampled in the same cycle as expiry takes priority and produces a normal result.
- Not defined: no counter, m_err tied 0, RUN waits indefinitely.

## Test plan
- Hash job: s_in1=5, s_mode=0, s_in2=0x1234. Engine model returns 0x0ABC_DEF0 after N=8.
  - eng_in2=0, eng_mode=0, eng_go high for exactly 8 cycles.
  - m_valid rises 9 cycles after accept; m_data=0x0ABC_DEF0, m_err=0.
- Compress with canonicalisation: s_in1=0x7FFF_FFFF, s_in2=0x7FFF_FFFE, s_mode=1 → eng_in1=0, eng_in2=0x7FFF_FFFE, eng_mode=1, both stable LOAD..DONE.
- Backpressure: m_ready=0 for 10 cycles after m_valid → m_valid, m_data and eng_go=0 held. s_ready=0 throughout; a new s_valid is not accepted until the cycle after m_ready=1.
- Back-to-back: two jobs, s_valid and m_ready held high → eng_go low for ≥2 cycles between runs; results are returned in order.
- Reset mid-RUN: assert reset_n=0 at cycle 4 of RUN → eng_go=0 and m_valid=0 immediately (async), s_ready=1 after release, no result is emitted for the aborted job.
- Watchdog (MONOLITH_SEQ_WDT_EN, TIMEOUT_CYCLES=16): engine never asserts eng_valid → m_valid at accept+17 cycles, m_data=0, m_err=1. Without the macro, m_valid stays 0 for ≥1000 cycles.

Source files
------------

// File: rtl/monolith_job_sequencer_if.sv
// Job request / result bundle between the host stream logic and the Monolith
// job sequencer.
//   s_valid, s_ready, s_in1, s_in2, s_mode : job request (host -> sequencer)
//   m_valid, m_ready, m_data, m_err        : result      (sequencer -> host)
// Modport master is the host side; modport slave is the sequencer side.
interface monolith_job_sequencer_if;
   localparam int unsigned DATA_W = 31;

   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_in1;
   logic [DATA_W-1:0] s_in2;
   logic              s_mode;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_err;

   modport master (
      output s_valid, s_in1, s_in2, s_mode, m_ready,
      input  s_ready, m_valid, m_data, m_err
   );

   modport slave (
      input  s_valid, s_in1, s_in2, s_mode, m_ready,
      output s_ready, m_valid, m_data, m_err
   );
endinterface

// File: rtl/monolith_job_sequencer.sv
// Front end for the Monolith hash engine. Takes one hash/compress job at a
// time, canonicalises operands modulo 2^31-1, sequences the engine through a
// one-cycle load (go low) followed by a run (go high), and returns the digest.
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   job (slave)         request s_valid/s_ready/s_in1/s_in2/s_mode and
//                       result m_valid/m_ready/m_data/m_err
//   eng_in1, eng_in2    engine operands, stable from load through result
//   eng_mode            engine hash(0)/compress(1) select
//   eng_go              engine go; low holds the engine in reset
//   eng_out, eng_valid  engine digest and its valid strobe
//
// Build option: define MONOLITH_SEQ_WDT_EN to abort a run after
// TIMEOUT_CYCLES run cycles with m_err=1 and m_data=0. Without it the run
// waits indefinitely and m_err stays 0.
module monolith_job_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    reset_n,
   monolith_job_sequencer_if.slave job,
   output logic [30:0]             eng_in1,
   output logic [30:0]             eng_in2,
   output logic                    eng_mode,
   output logic                    eng_go,
   input  logic [30:0]             eng_out,
   input  logic                    eng_valid
);
   localparam int unsigned DATA_W = 31;
   localparam logic [DATA_W-1:0] P_MOD = {DATA_W{1'b1}};

   // Elaboration-time range check on the watchdog limit.
   if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
      $error("TIMEOUT_CYCLES must be in 1..65535");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_e;

   state_e              state_q,   state_d;
   logic                s_ready_q, s_ready_d;
   logic                m_valid_q, m_valid_d;
   logic [DATA_W-1:0]   m_data_q,  m_data_d;
   logic                m_err_q,   m_err_d;
   logic [DATA_W-1:0]   in1_q,     in1_d;
   logic [DATA_W-1:0]   in2_q,     in2_d;
   logic                mode_q,    mode_d;
   logic                go_q,      go_d;

`ifdef MONOLITH_SEQ_WDT_EN
   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0]    cnt_q,     cnt_d;
`endif

   // p itself is congruent to zero; every other 31-bit value is already reduced.
   function automatic logic [DATA_W-1:0] canon(input logic [DATA_W-1:0] x);
      return (x == P_MOD) ? '0 : x;
   endfunction

   // Next-state and next-register computation.
   always_comb begin
      state_d  = state_q;
      m_data_d = m_data_q;
      m_err_d  = m_err_q;
      in1_d    = in1_q;
      in2_d    = in2_q;
      mode_d   = mode_q;
`ifdef MONOLITH_SEQ_WDT_EN
      cnt_d    = cnt_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (job.s_valid && s_ready_q) begin
               in1_d   = canon(job.s_in1);
               in2_d   = job.s_mode ? canon(job.s_in2) : '0;
               mode_d  = job.s_mode;
               state_d = LOAD;
            end
         end
         LOAD: begin
`ifdef MONOLITH_SEQ_WDT_EN
            cnt_d   = '0;
`endif
            state_d = RUN;
         end
         RUN: begin
            // A result arriving on the expiry cycle wins over the abort.
            if (eng_valid) begin
               m_data_d = eng_out;
               m_err_d  = 1'b0;
               state_d  = DONE;
            end
`ifdef MONOLITH_SEQ_WDT_EN
            else if (cnt_q == CNT_LAST) begin
               m_data_d = '0;
               m_err_d  = 1'b1;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         DONE: begin
            if (job.m_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Handshake and go outputs are decoded from the next state so they are
      // registered alongside it.
      s_ready_d = (state_d == IDLE);
      go_d      = (state_d == RUN);
      m_valid_d = (state_d == DONE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         s_ready_q <= 1'b1;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_err_q   <= 1'b0;
         in1_q     <= '0;
         in2_q     <= '0;
         mode_q    <= 1'b0;
         go_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         s_ready_q <= s_ready_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_err_q   <= m_err_d;
         in1_q     <= in1_d;
         in2_q     <= in2_d;
         mode_q    <= mode_d;
         go_q      <= go_d;
      end
   end

`ifdef MONOLITH_SEQ_WDT_EN
   // Run-cycle watchdog counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   assign job.s_ready = s_ready_q;
   assign job.m_valid = m_valid_q;
   assign job.m_data  = m_data_q;
   assign job.m_err   = m_err_q;
   assign eng_in1     = in1_q;
   assign eng_in2     = in2_q;
   assign eng_mode    = mode_q;
   assign eng_go      = go_q;
endmodule
